// File: rtl/di_pkg.sv
// Shared DI constants: address/data widths, default endpoint/register
// addresses, prefetch defaults and the reader controller state encoding.
package di_pkg;

    localparam int DI_ADDR_W = 16;
    localparam int DI_DATA_W = 16;

    localparam logic [DI_ADDR_W-1:0] DI_EP_ADDR_DEF  = 16'h0000;
    localparam logic [DI_ADDR_W-1:0] DI_REG_ADDR_DEF = 16'h0000;

    localparam int DI_DEPTH_DEF = 4;

    // The host may issue one more read after rd_ready drops, so READY needs
    // two committed words: one for the read in progress, one for the extra.
    localparam int DI_READY_THRESH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_FLUSH = 2'd3
    } di_state_t;

endpackage

// File: rtl/di_prefetch_buf.sv
// Circular prefetch buffer: DEPTH entries, push at the tail, pop from the
// head, occupancy count. Push and pop may occur in the same cycle.
module di_prefetch_buf
    import di_pkg::*;
#(
    parameter int DATA_W = DI_DATA_W,
    parameter int DEPTH  = DI_DEPTH_DEF
) (
    input  logic                     if_clock,
    input  logic                     resetb,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;

    // Storage array: data only, no reset needed since occupancy guards reads.
    always_ff @(posedge if_clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign occupancy = occ_q;

endmodule

// File: rtl/di_fifo_reader.sv
// DI read path: prefetches words from a source FIFO into a small buffer and
// predicts read readiness to the host interface one cycle ahead.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | address not selected; buffer retained, no new pops
//   ST_FILL  | selected, fewer than two words committed
//   ST_READY | selected, at least two words committed (rd_ready high)
//   ST_FLUSH | one-cycle discard after diReset; no pops, landing dropped
module di_fifo_reader
    import di_pkg::*;
#(
    parameter int                    DATA_W   = DI_DATA_W,
    parameter logic [DI_ADDR_W-1:0]  EP_ADDR  = DI_EP_ADDR_DEF,
    parameter logic [DI_ADDR_W-1:0]  REG_ADDR = DI_REG_ADDR_DEF,
    parameter int                    DEPTH    = DI_DEPTH_DEF
) (
    input  logic                  if_clock,
    input  logic                  resetb,
    input  logic [DI_ADDR_W-1:0]  diEpAddr,
    input  logic [DI_ADDR_W-1:0]  diRegAddr,
    input  logic                  diRead,
    input  logic                  diReset,
    output logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_W-1:0]     fifo_dout,
    output logic                  underflow
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = OCC_W + 1;

    di_state_t          state_q;
    di_state_t          state_d;
    logic               inflight_q;
    logic               sel;
    logic               flushing;
    logic               have_word;
    logic               rd_acc;
    logic               rd_under;
    logic               land;
    logic               buf_push;
    logic               buf_pop;
    logic [OCC_W-1:0]   occ;
    logic [DATA_W-1:0]  head_data;
    logic [CNT_W-1:0]   base_cnt;
    logic [CNT_W-1:0]   committed_d;

    assign sel      = (diEpAddr == EP_ADDR) && (diRegAddr == REG_ADDR);
    assign flushing = diReset || (state_q == ST_FLUSH);

    // A read can be served from the buffer or straight from a landing word.
    assign have_word = (occ != '0) || inflight_q;
    assign rd_acc    = sel && diRead && !flushing && have_word;
    assign rd_under  = sel && diRead && !flushing && !have_word;

    // A landing word that meets a read on an empty buffer bypasses storage.
    assign land     = inflight_q && !flushing;
    assign buf_push = land && !(rd_acc && (occ == '0));
    assign buf_pop  = rd_acc && (occ != '0);

    // Words still owed to the host after this edge, before any new pop.
    assign base_cnt = CNT_W'(occ) + CNT_W'(inflight_q) - CNT_W'(rd_acc);

    assign fifo_rd_en = resetb && sel && !fifo_empty && !flushing &&
                        (base_cnt < CNT_W'(DEPTH));

    assign committed_d = base_cnt + CNT_W'(fifo_rd_en);

    di_prefetch_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .if_clock  (if_clock),
        .resetb    (resetb),
        .flush     (flushing),
        .push      (buf_push),
        .push_data (fifo_dout),
        .pop       (buf_pop),
        .head_data (head_data),
        .occupancy (occ)
    );

    // Next-state decode; diReset overrides everything, FLUSH lasts one cycle.
    always_comb begin
        state_d = state_q;
        if (diReset) begin
            state_d = ST_FLUSH;
        end else if (!sel) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_FILL;
        end else if (committed_d >= CNT_W'(DI_READY_THRESH)) begin
            state_d = ST_READY;
        end else begin
            state_d = ST_FILL;
        end
    end

    // State, in-flight flag and registered host-facing outputs.
    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            rd_ready   <= 1'b0;
            rd_data    <= '0;
            underflow  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            rd_ready   <= (state_d == ST_READY);
            if (rd_acc) begin
                rd_data <= (occ != '0) ? head_data : fifo_dout;
            end
            if (diReset) begin
                underflow <= 1'b0;
            end else if (rd_under) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_di_fifo_reader.sv
// Scoreboarded bench for di_fifo_reader with a behavioural source FIFO.
module tb_di_fifo_reader;

    localparam logic [15:0] EP = 16'h0012;
    localparam logic [15:0] RG = 16'h0034;

    logic        if_clock = 1'b0;
    logic        resetb   = 1'b0;
    logic [15:0] diEpAddr;
    logic [15:0] diRegAddr;
    logic        diRead;
    logic        diReset;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout = 16'h0;
    logic        underflow;

    always #5 if_clock = ~if_clock;

    di_fifo_reader #(
        .DATA_W   (16),
        .EP_ADDR  (EP),
        .REG_ADDR (RG),
        .DEPTH    (4)
    ) dut (
        .if_clock   (if_clock),
        .resetb     (resetb),
        .diEpAddr   (diEpAddr),
        .diRegAddr  (diRegAddr),
        .diRead     (diRead),
        .diReset    (diReset),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .underflow  (underflow)
    );

    // Source FIFO model
    logic [15:0] src_mem [256];
    int src_rd = 0;
    int src_wr = 0;
    int rd_en_cnt = 0;
    int rdy_rise = 0;
    logic rdy_prev = 1'b0;

    assign fifo_empty = (src_rd == src_wr);

    always @(posedge if_clock) begin
        if (fifo_rd_en) begin
            fifo_dout <= src_mem[src_rd];
            src_rd    <= src_rd + 1;
            rd_en_cnt <= rd_en_cnt + 1;
        end
        rdy_prev <= rd_ready;
        if (rd_ready && !rdy_prev) rdy_rise <= rdy_rise + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: host pushes expected words; monitor pops after each read edge.
    logic rd_expect = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge if_clock) begin
        if (resetb && diRead && rd_expect) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: read with no expected word, rd_data=0x%0h", rd_data);
            end else begin
                chk("sb_rd_data", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_sel(input logic s);
        diEpAddr  = EP;
        diRegAddr = s ? RG : 16'h0035;
    endtask

    // Host: reads while rd_ready, plus the one allowed read after it falls.
    task automatic host_read(input int n, input logic [15:0] first, input int budget,
                             output int cycles);
        int issued;
        logic prev;
        issued = 0;
        prev   = 1'b0;
        cycles = 0;
        while (issued < n && cycles < budget) begin
            @(negedge if_clock);
            if (rd_ready || prev) begin
                diRead    = 1'b1;
                rd_expect = 1'b1;
                exp_q.push_back(first + 16'(issued));
                issued++;
            end else begin
                diRead    = 1'b0;
                rd_expect = 1'b0;
            end
            prev = rd_ready;
            cycles++;
        end
        @(negedge if_clock);
        diRead    = 1'b0;
        rd_expect = 1'b0;
        chk("host_count", issued, n);
    endtask

    int cyc;
    int cnt0;
    int rise0;

    initial begin
        diRead  = 1'b0;
        diReset = 1'b0;
        set_sel(1'b0);

        // Reset state, with selection and source data present during reset
        for (int i = 0; i < 16; i++) src_mem[i] = 16'h0001 + 16'(i);
        src_wr = 16;
        set_sel(1'b1);
        #12;
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_no_pop", src_rd, 0);

        // Streaming 0x0001..0x0010 with no gaps
        @(negedge if_clock);
        resetb = 1'b1;
        host_read(16, 16'h0001, 100, cyc);
        chk("t1_read_cycles", cyc, 17);
        repeat (2) @(negedge if_clock);
        chk("t1_underflow", underflow, 0);
        chk("t1_rd_ready_low", rd_ready, 0);

        // Empty source: one read underflows
        resetb = 1'b0;
        @(negedge if_clock);
        resetb = 1'b1;
        cnt0 = rd_en_cnt;
        repeat (2) @(negedge if_clock);
        diRead = 1'b1;
        @(negedge if_clock);
        diRead = 1'b0;
        repeat (2) @(negedge if_clock);
        chk("t2_underflow", underflow, 1);
        chk("t2_rd_data_hold", rd_data, 0);
        chk("t2_no_pops", rd_en_cnt - cnt0, 0);
        chk("t2_rd_ready", rd_ready, 0);

        // Full buffer retained across deselect
        diReset = 1'b1;
        @(negedge if_clock);
        diReset = 1'b0;
        chk("t3_underflow_cleared", underflow, 0);
        for (int i = 0; i < 6; i++) src_mem[16+i] = 16'h0101 + 16'(i);
        src_wr = 22;
        repeat (8) @(negedge if_clock);
        chk("t3_filled_pops", src_rd, 20);
        chk("t3_ready_full", rd_ready, 1);
        set_sel(1'b0);
        cnt0 = rd_en_cnt;
        repeat (20) @(negedge if_clock);
        chk("t3_desel_no_pops", rd_en_cnt - cnt0, 0);
        chk("t3_desel_rd_ready", rd_ready, 0);
        set_sel(1'b1);
        host_read(6, 16'h0101, 100, cyc);
        chk("t3_underflow", underflow, 0);

        // diReset with a word in flight
        repeat (2) @(negedge if_clock);
        diRead = 1'b1;
        @(negedge if_clock);
        diRead = 1'b0;
        chk("t4_underflow_set", underflow, 1);
        for (int i = 0; i < 3; i++) src_mem[22+i] = 16'h0201 + 16'(i);
        src_wr = 25;
        @(negedge if_clock);
        chk("t4_inflight_pop", src_rd, 23);
        diReset = 1'b1;
        #1;
        chk("t4_no_pop_on_reset", fifo_rd_en, 0);
        @(negedge if_clock);
        diReset = 1'b0;
        chk("t4_rd_ready", rd_ready, 0);
        chk("t4_underflow_clr", underflow, 0);
        chk("t4_flush_no_pop", fifo_rd_en, 0);
        chk("t4_src_rd", src_rd, 23);
        host_read(2, 16'h0202, 50, cyc);

        // Slow source: one word every 3 cycles
        repeat (3) @(negedge if_clock);
        for (int i = 0; i < 8; i++) src_mem[25+i] = 16'h0301 + 16'(i);
        rise0 = rdy_rise;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    src_wr = src_wr + 1;
                    repeat (3) @(negedge if_clock);
                end
            end
            begin
                int c5;
                host_read(8, 16'h0301, 200, c5);
            end
        join
        repeat (3) @(negedge if_clock);
        chk("t5_underflow", underflow, 0);
        chk("t5_ready_rises", rdy_rise - rise0, 4);
        chk("t5_rd_ready_low", rd_ready, 0);

        // Asynchronous reset mid-stream, then refill
        for (int i = 0; i < 16; i++) src_mem[33+i] = 16'h0401 + 16'(i);
        src_wr = 49;
        host_read(3, 16'h0401, 50, cyc);
        repeat (5) @(negedge if_clock);
        chk("t6_prefill", src_rd, 40);
        chk("t6_ready_before", rd_ready, 1);
        @(posedge if_clock);
        #3;
        resetb = 1'b0;
        #1;
        chk("t6_async_rd_ready", rd_ready, 0);
        chk("t6_async_rd_data", rd_data, 0);
        chk("t6_async_underflow", underflow, 0);
        chk("t6_async_fifo_rd_en", fifo_rd_en, 0);
        @(negedge if_clock);
        chk("t6_rst_fifo_rd_en", fifo_rd_en, 0);
        chk("t6_rst_src_rd", src_rd, 40);
        resetb = 1'b1;
        host_read(4, 16'h0408, 50, cyc);

        repeat (3) @(negedge if_clock);
        chk("sb_drained", exp_q.size(), 0);
        chk("final_underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
